// File: rtl/ctrl_pipe_pkg.sv
// Shared control types for the RV32I pipeline control unit: opcode and
// sub-field enums, the per-stage control word and its NOP value.
// The RV32M decode path is enabled by defining CTRL_RV32M_EN.
package ctrl_pipe_pkg;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011,
    OP_FENCE = 7'b0001111,
    OP_CSR   = 7'b1110011
  } rv32i_opcode_t;

  // Encoded so that op_imm/op_reg funct3 maps straight onto the ALU op.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops_t;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    md_mul    = 3'b000,
    md_mulh   = 3'b001,
    md_mulhsu = 3'b010,
    md_mulhu  = 3'b011,
    md_div    = 3'b100,
    md_divu   = 3'b101,
    md_rem    = 3'b110,
    md_remu   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic {
    alumux1_rs1 = 1'b0,
    alumux1_pc  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    alumux2_i_imm = 3'd0,
    alumux2_u_imm = 3'd1,
    alumux2_b_imm = 3'd2,
    alumux2_s_imm = 3'd3,
    alumux2_j_imm = 3'd4,
    alumux2_rs2   = 3'd5
  } alumux2_sel_t;

  typedef enum logic {
    cmpmux_rs2   = 1'b0,
    cmpmux_i_imm = 1'b1
  } cmpmux_sel_t;

  typedef enum logic [3:0] {
    rf_alu_out  = 4'd0,
    rf_br_en    = 4'd1,
    rf_u_imm    = 4'd2,
    rf_lw       = 4'd3,
    rf_pc_plus4 = 4'd4,
    rf_lb       = 4'd5,
    rf_lbu      = 4'd6,
    rf_lh       = 4'd7,
    rf_lhu      = 4'd8
  } regfilemux_sel_t;

  // Register fields are zero when the instruction does not use them, so
  // hazard logic downstream can compare them without qualifying by opcode.
  typedef struct packed {
    logic            illegal;
    logic            csr;
    logic            branch;
    logic            jump;
    logic            muldiv;
    muldiv_funct3_t  muldiv_op;
    alu_ops_t        alu_op;
    branch_funct3_t  cmp_op;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    cmpmux_sel_t     cmpmux_sel;
    regfilemux_sel_t regfilemux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } ctrl_word_t;

  localparam int CTRL_W = $bits(ctrl_word_t);

  // Every enum above has its "do nothing" member at zero.
  localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Combinational RV32I instruction decoder: instr -> control word + illegal.
// Defining CTRL_RV32M_EN makes op_reg with funct7=0000001 a legal mul/div.
module ctrl_decode
  import ctrl_pipe_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_word_t  ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       use_rs1;
  logic       use_rs2;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Opcode-driven field mapping; any illegal encoding collapses to NOP.
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = rf_u_imm;
      end
      OP_AUIPC: begin
        ctrl.load_regfile = 1'b1;
        ctrl.alumux1_sel  = alumux1_pc;
        ctrl.alumux2_sel  = alumux2_u_imm;
      end
      OP_JAL: begin
        ctrl.jump           = 1'b1;
        ctrl.load_regfile   = 1'b1;
        ctrl.alumux1_sel    = alumux1_pc;
        ctrl.alumux2_sel    = alumux2_j_imm;
        ctrl.regfilemux_sel = rf_pc_plus4;
      end
      OP_JALR: begin
        ctrl.jump           = 1'b1;
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = rf_pc_plus4;
        ctrl.funct3         = funct3;
        use_rs1             = 1'b1;
      end
      OP_BR: begin
        ctrl.branch      = 1'b1;
        ctrl.cmp_op      = branch_funct3_t'(funct3);
        ctrl.alumux1_sel = alumux1_pc;
        ctrl.alumux2_sel = alumux2_b_imm;
        ctrl.funct3      = funct3;
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
      end
      OP_LOAD: begin
        ctrl.mem_read     = 1'b1;
        ctrl.load_regfile = 1'b1;
        ctrl.funct3       = funct3;
        use_rs1           = 1'b1;
        case (funct3)
          lb:      ctrl.regfilemux_sel = rf_lb;
          lh:      ctrl.regfilemux_sel = rf_lh;
          lbu:     ctrl.regfilemux_sel = rf_lbu;
          lhu:     ctrl.regfilemux_sel = rf_lhu;
          default: ctrl.regfilemux_sel = rf_lw;
        endcase
      end
      OP_STORE: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alumux2_sel = alumux2_s_imm;
        ctrl.funct3      = funct3;
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
      end
      OP_IMM: begin
        ctrl.load_regfile = 1'b1;
        ctrl.funct3       = funct3;
        use_rs1           = 1'b1;
        case (funct3)
          3'b010: begin
            ctrl.cmp_op         = blt;
            ctrl.cmpmux_sel     = cmpmux_i_imm;
            ctrl.regfilemux_sel = rf_br_en;
          end
          3'b011: begin
            ctrl.cmp_op         = bltu;
            ctrl.cmpmux_sel     = cmpmux_i_imm;
            ctrl.regfilemux_sel = rf_br_en;
          end
          3'b001: begin
            if (funct7 == 7'b0000000) ctrl.alu_op = alu_sll;
            else                      illegal     = 1'b1;
          end
          3'b101: begin
            if      (funct7 == 7'b0000000) ctrl.alu_op = alu_srl;
            else if (funct7 == 7'b0100000) ctrl.alu_op = alu_sra;
            else                           illegal     = 1'b1;
          end
          default: ctrl.alu_op = alu_ops_t'(funct3);
        endcase
      end
      OP_REG: begin
        ctrl.load_regfile = 1'b1;
        ctrl.alumux2_sel  = alumux2_rs2;
        ctrl.funct3       = funct3;
        use_rs1           = 1'b1;
        use_rs2           = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b010: begin
                ctrl.cmp_op         = blt;
                ctrl.regfilemux_sel = rf_br_en;
              end
              3'b011: begin
                ctrl.cmp_op         = bltu;
                ctrl.regfilemux_sel = rf_br_en;
              end
              default: ctrl.alu_op = alu_ops_t'(funct3);
            endcase
          end
          7'b0100000: begin
            if      (funct3 == 3'b000) ctrl.alu_op = alu_sub;
            else if (funct3 == 3'b101) ctrl.alu_op = alu_sra;
            else                       illegal     = 1'b1;
          end
`ifdef CTRL_RV32M_EN
          7'b0000001: begin
            ctrl.muldiv    = 1'b1;
            ctrl.muldiv_op = muldiv_funct3_t'(funct3);
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_FENCE: ctrl = CTRL_NOP;
      OP_CSR: begin
        ctrl     = CTRL_NOP;
        ctrl.csr = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    ctrl.rd  = ctrl.load_regfile ? instr[11:7]  : 5'd0;
    ctrl.rs1 = use_rs1           ? instr[19:15] : 5'd0;
    ctrl.rs2 = use_rs2           ? instr[24:20] : 5'd0;

    if (illegal) ctrl = CTRL_NOP;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the fetched instruction and carries the
// control word plus a valid bit through NUM_STAGES registers (1=EX .. N=WB),
// with stall, load-use bubble, partial flush and a retire counter.
// Optional RV32M decode via CTRL_RV32M_EN (handled inside ctrl_decode).
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_vld,
  input  logic [31:0]                  instr,
  input  logic                         stall,
  input  logic                         bubble,
  input  logic                         flush,
  output logic                         dec_ready,
  output logic [NUM_STAGES*CTRL_W-1:0] ctrl_o,
  output logic [NUM_STAGES-1:0]        vld_o,
  output logic                         illegal_o,
  output logic [CNT_W-1:0]             retire_cnt
);

  ctrl_word_t                  dec_ctrl;
  logic                        dec_illegal;
  ctrl_word_t                  dec_word;
  logic       [NUM_STAGES:1]   vld_pipe;
  ctrl_word_t [NUM_STAGES:1]   ctrl_pipe;

  ctrl_decode u_decode (
    .instr   (instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Fold the illegal flag into the word so it travels with the instruction.
  always_comb begin
    dec_word         = dec_ctrl;
    dec_word.illegal = dec_illegal;
  end

  // Stage registers; per stage: flush > stall > bubble > advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      ctrl_pipe <= {NUM_STAGES{CTRL_NOP}};
    end else begin
      if (flush) begin
        vld_pipe[1]  <= 1'b0;
        ctrl_pipe[1] <= CTRL_NOP;
      end else if (!stall) begin
        if (bubble || !instr_vld) begin
          vld_pipe[1]  <= 1'b0;
          ctrl_pipe[1] <= CTRL_NOP;
        end else begin
          vld_pipe[1]  <= 1'b1;
          ctrl_pipe[1] <= dec_word;
        end
      end
      for (int k = 2; k <= NUM_STAGES; k++) begin
        if (flush && k <= FLUSH_DEPTH) begin
          vld_pipe[k]  <= 1'b0;
          ctrl_pipe[k] <= CTRL_NOP;
        end else if (!stall) begin
          vld_pipe[k]  <= vld_pipe[k-1];
          ctrl_pipe[k] <= ctrl_pipe[k-1];
        end
      end
    end
  end

  // Count words leaving the last stage; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             retire_cnt <= '0;
    else if (!stall && vld_pipe[NUM_STAGES]) retire_cnt <= retire_cnt + CNT_W'(1);
  end

  assign dec_ready = !stall && !bubble;
  assign ctrl_o    = ctrl_pipe;
  assign vld_o     = vld_pipe;
  assign illegal_o = vld_pipe[1] && ctrl_pipe[1].illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus randomized
// traffic compared every cycle against a behavioural pipeline model.
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  localparam int N  = 4;
  localparam int FD = 2;
  localparam int CW = 4;
`ifdef CTRL_RV32M_EN
  localparam bit RV32M = 1'b1;
`else
  localparam bit RV32M = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_vld, stall, bubble, flush;
  logic [31:0]       instr;
  logic              dec_ready, illegal_o;
  logic [N*CTRL_W-1:0] ctrl_o;
  logic [N-1:0]      vld_o;
  logic [CW-1:0]     retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  logic [N:1]  m_vld;
  ctrl_word_t  m_ctrl [1:N];
  int          m_cnt;
  bit          chk_en = 1'b0;

  ctrl_pipe #(.NUM_STAGES(N), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_vld(instr_vld), .instr(instr),
    .stall(stall), .bubble(bubble), .flush(flush), .dec_ready(dec_ready),
    .ctrl_o(ctrl_o), .vld_o(vld_o), .illegal_o(illegal_o), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ctrl_word_t stage(int k);
    return ctrl_o[k*CTRL_W-1 -: CTRL_W];
  endfunction

  // Reference decode written field by field from the ISA rules.
  function automatic ctrl_word_t ref_decode(logic [31:0] w);
    ctrl_word_t c = CTRL_NOP;
    logic [6:0] op = w[6:0];
    logic [6:0] f7 = w[31:25];
    logic [2:0] f3 = w[14:12];
    bit lui = op == 7'h37, auipc = op == 7'h17, jal = op == 7'h6F, jalr = op == 7'h67;
    bit br = op == 7'h63, ld = op == 7'h03, st = op == 7'h23, imm = op == 7'h13;
    bit rg = op == 7'h33, fence = op == 7'h0F, csr = op == 7'h73;
    bit md = rg && f7 == 7'h01;
    bit alt = f7 == 7'h20;
    bit slt_op = (imm || (rg && f7 == 7'h00)) && f3[2:1] == 2'b01;
    bit uses_r1 = jalr | br | ld | st | imm | rg;
    bit legal;
    if (imm)     legal = (f3 == 3'b001) ? (f7 == 7'h00) : (f3 == 3'b101) ? (f7 == 7'h00 || alt) : 1'b1;
    else if (rg) legal = f7 == 7'h00 || (alt && (f3 == 3'b000 || f3 == 3'b101)) || (md && RV32M);
    else         legal = lui | auipc | jal | jalr | br | ld | st | fence | csr;
    if (!legal) begin c.illegal = 1'b1; return c; end
    if (fence || csr) begin c.csr = csr; return c; end
    c.load_regfile = lui | auipc | jal | jalr | ld | imm | rg;
    c.mem_read  = ld;
    c.mem_write = st;
    c.branch    = br;
    c.jump      = jal | jalr;
    c.muldiv    = md;
    if (md) c.muldiv_op = muldiv_funct3_t'(f3);
    if (md) c.alu_op = alu_add;
    else if (alt && (rg || (imm && f3 == 3'b101))) c.alu_op = (f3 == 3'b000) ? alu_sub : alu_sra;
    else if ((imm || rg) && !slt_op) c.alu_op = alu_ops_t'(f3);
    if (br)          c.cmp_op = branch_funct3_t'(f3);
    else if (slt_op) c.cmp_op = f3[0] ? bltu : blt;
    c.cmpmux_sel  = (slt_op && imm) ? cmpmux_i_imm : cmpmux_rs2;
    c.alumux1_sel = (auipc | jal | br) ? alumux1_pc : alumux1_rs1;
    c.alumux2_sel = auipc ? alumux2_u_imm : jal ? alumux2_j_imm : br ? alumux2_b_imm :
                    st ? alumux2_s_imm : rg ? alumux2_rs2 : alumux2_i_imm;
    if (lui)              c.regfilemux_sel = rf_u_imm;
    else if (jal || jalr) c.regfilemux_sel = rf_pc_plus4;
    else if (ld)          c.regfilemux_sel = (f3 == 3'b000) ? rf_lb : (f3 == 3'b001) ? rf_lh :
                                             (f3 == 3'b100) ? rf_lbu : (f3 == 3'b101) ? rf_lhu : rf_lw;
    else if (slt_op)      c.regfilemux_sel = rf_br_en;
    c.funct3 = uses_r1 ? f3 : 3'b000;
    c.rd  = c.load_regfile ? w[11:7] : 5'd0;
    c.rs1 = uses_r1 ? w[19:15] : 5'd0;
    c.rs2 = (br | st | rg) ? w[24:20] : 5'd0;
    return c;
  endfunction

  task automatic model_reset();
    m_vld = '0;
    for (int k = 1; k <= N; k++) m_ctrl[k] = CTRL_NOP;
    m_cnt = 0;
  endtask

  // One clock of the pipeline as a list: shift in unless stalled, then flush.
  task automatic model_edge();
    logic [N:1] nv = m_vld;
    ctrl_word_t nc [1:N] = m_ctrl;
    if (!stall) begin
      if (m_vld[N]) m_cnt = (m_cnt + 1) % (1 << CW);
      for (int k = N; k >= 2; k--) begin nv[k] = m_vld[k-1]; nc[k] = m_ctrl[k-1]; end
      nv[1] = instr_vld && !bubble;
      nc[1] = ref_decode(instr);
    end
    if (flush) for (int k = 1; k <= FD; k++) nv[k] = 1'b0;
    m_vld = nv;
    m_ctrl = nc;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  // Async reset pulse placed between clock edges.
  task automatic mid_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst vld_o", vld_o, 0);
    check("rst retire_cnt", retire_cnt, 0);
    check("rst ctrl_o", ctrl_o == '0, 1);
    check("rst illegal_o", illegal_o, 0);
    #2;
    rst = 1'b0;
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int k = 1; k <= N; k++) begin
        check($sformatf("vld[%0d]", k), vld_o[k-1], m_vld[k]);
        if (m_vld[k]) check($sformatf("ctrl[%0d]", k), stage(k), m_ctrl[k]);
      end
      check("illegal_o", illegal_o, m_vld[1] && m_ctrl[1].illegal);
      check("retire_cnt", retire_cnt, m_cnt);
      check("dec_ready", dec_ready, !stall && !bubble);
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    logic [31:0] w = $urandom;
    int s = $urandom_range(0, 12);
    if (s < 11) w[6:0] = ops[s];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h0000A103;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] MUL  = 32'h022081B3;

  initial begin
    ctrl_word_t s;
    rst = 1'b1; instr_vld = 1'b0; instr = '0; stall = 1'b0; bubble = 1'b0; flush = 1'b0;
    model_reset();
    #12 rst = 1'b0;
    chk_en = 1'b1;

    // model pinned against hand-decoded words
    s = ref_decode(ADDI);
    check("ref addi", {s.alu_op, s.alumux2_sel, s.load_regfile, s.rd}, {alu_add, alumux2_i_imm, 1'b1, 5'd1});
    s = ref_decode(MUL);
    check("ref mul illegal", s.illegal, !RV32M);

    // reset mid-run
    instr = ADDI; instr_vld = 1'b1;
    repeat (6) cyc();
    mid_reset();

    // decode latency
    instr = ADDI; instr_vld = 1'b1;
    cyc();
    s = stage(1);
    check("t2 alu_op", s.alu_op, alu_add);
    check("t2 alumux2", s.alumux2_sel, alumux2_i_imm);
    check("t2 load_regfile", s.load_regfile, 1);
    check("t2 vld t+1", vld_o, 4'b0001);
    instr_vld = 1'b0;
    repeat (3) cyc();
    check("t2 vld t+4", vld_o, 4'b1000);
    cyc();
    check("t2 retire t+5", retire_cnt, 1);

    // load-use bubble
    instr = LW; instr_vld = 1'b1;
    cyc();
    instr = ADD; bubble = 1'b1;
    #1 check("t3 dec_ready", dec_ready, 0);
    cyc();
    check("t3 s1 vld", vld_o[0], 0);
    check("t3 s2 vld", vld_o[1], 1);
    s = stage(2);
    check("t3 s2 mem_read", s.mem_read, 1);
    check("t3 s2 rfmux", s.regfilemux_sel, rf_lw);
    bubble = 1'b0;
    cyc();
    s = stage(1);
    check("t3 add after bubble", {vld_o[0], s.alumux2_sel, s.rd}, {1'b1, alumux2_rs2, 5'd3});

    // flush under stall
    instr = 32'h123452B7; cyc();   // lui x5
    instr = 32'h00001317; cyc();   // auipc x6
    instr = 32'h0020A223; cyc();   // sw x2,4(x1)
    instr = 32'h00208463; cyc();   // beq x1,x2
    check("t4 full", vld_o, 4'b1111);
    stall = 1'b1; flush = 1'b1;
    cyc();
    check("t4 vld", vld_o, 4'b1100);
    s = stage(4);
    check("t4 s4 lui", {s.regfilemux_sel, s.load_regfile, s.rd}, {rf_u_imm, 1'b1, 5'd5});
    s = stage(3);
    check("t4 s3 auipc", {s.alumux1_sel, s.alumux2_sel, s.rd}, {alumux1_pc, alumux2_u_imm, 5'd6});
    stall = 1'b0; flush = 1'b0;

    // illegal encodings
    instr = 32'hFFFFFFFF;
    cyc();
    s = stage(1);
    check("t5 illegal_o", illegal_o, 1);
    check("t5 nop fields", {s.load_regfile, s.mem_write, s.mem_read}, 3'b000);
    instr = MUL;
    cyc();
    s = stage(1);
    check("t5 mul illegal_o", illegal_o, !RV32M);
    check("t5 mul muldiv", s.muldiv, RV32M);

    // counter wrap at 2^4
    instr_vld = 1'b0;
    cyc();
    mid_reset();
    instr = ADDI; instr_vld = 1'b1;
    repeat (17) cyc();
    instr_vld = 1'b0;
    repeat (4) cyc();
    check("t6 wrap", retire_cnt, 1);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      instr_vld = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      stall     = ($urandom_range(0, 7) == 0);
      bubble    = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      cyc();
    end
    instr_vld = 1'b0; stall = 1'b0; bubble = 1'b0; flush = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
